// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: shared types for the fetch->execute path.
//   word_t      : 32-bit machine word
//   fe_bundle_t : per-instruction bundle handed from fetch to execute
//   next_pc     : resolved next PC of a control-flow instruction
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
    word_t pc4;
    word_t prediction;
  } fe_bundle_t;

  function automatic word_t next_pc(input logic taken, input word_t target, input word_t pc4);
    return taken ? target : pc4;
  endfunction

endpackage

// File: rtl/fe_exec_buffer_if.sv
// fe_exec_buffer_if: handshake/bus bundle around fe_exec_buffer.
//   fetch side   : f_valid/f_ready + f_pc, f_instr, f_pc4, f_prediction
//   execute side : e_valid/e_ready + e_pc, e_instr, e_pc4, e_prediction
//   resolution   : resolve, resolve_taken, resolve_target (sampled on dequeue)
//   control      : flush in; brj_addr, redirect, count out
// Modports: slave = the buffer, master = the fetch/execute environment.
interface fe_exec_buffer_if #(
  parameter int DEPTH = 2
);
  import rv32i_types_pkg::*;

  logic  f_valid;
  logic  f_ready;
  word_t f_pc, f_instr, f_pc4, f_prediction;
  logic  e_valid;
  logic  e_ready;
  word_t e_pc, e_instr, e_pc4, e_prediction;
  logic  resolve;
  logic  resolve_taken;
  word_t resolve_target;
  logic  flush;
  word_t brj_addr;
  logic  redirect;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  f_valid, f_pc, f_instr, f_pc4, f_prediction,
    input  e_ready, resolve, resolve_taken, resolve_target, flush,
    output f_ready, e_valid, e_pc, e_instr, e_pc4, e_prediction,
    output brj_addr, redirect, count
  );

  modport master (
    output f_valid, f_pc, f_instr, f_pc4, f_prediction,
    output e_ready, resolve, resolve_taken, resolve_target, flush,
    input  f_ready, e_valid, e_pc, e_instr, e_pc4, e_prediction,
    input  brj_addr, redirect, count
  );

endinterface

// File: rtl/fe_bundle_fifo.sv
// fe_bundle_fifo: DEPTH-entry FIFO of fe_bundle_t (DEPTH power of two, >=2).
//   push/push_data : write at tail (ignored when full)
//   pop            : advance head (ignored when empty)
//   clear          : drop every entry, wins over push/pop
//   head           : oldest entry, reads 0 when empty
//   count/full/empty : occupancy
module fe_bundle_fifo
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       push,
  input  fe_bundle_t push_data,
  input  logic       pop,
  input  logic       clear,
  output fe_bundle_t head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fe_bundle_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q;
  logic            push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally: DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; head is masked while empty.
  always_ff @(posedge CLK) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fe_exec_buffer.sv
// fe_exec_buffer: buffers fetch bundles for execute and checks branch
// resolution against the fetch prediction.
//   CLK, nRST : clock, async active-low reset
//   bus       : fe_exec_buffer_if.slave (fetch/execute handshakes, resolution,
//               flush, brj_addr/redirect back to fetch, occupancy)
// Optional build macro FE_EXEC_BYPASS_EN: when the FIFO is empty and no
// redirect is pending, the fetch bundle is presented to execute in the same
// cycle (zero latency); if execute takes it, it is never written.
module fe_exec_buffer
  import rv32i_types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic CLK,
  input logic nRST,
  fe_exec_buffer_if.slave bus
);
  fe_bundle_t f_bundle, fifo_head, e_bundle;
  logic       push, pop, clear, full, empty;
  logic       byp, e_valid, deq, mispredict;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  word_t      actual;
  logic       redirect_q;
  word_t      brj_q;

  assign f_bundle = '{pc: bus.f_pc, instr: bus.f_instr, pc4: bus.f_pc4,
                      prediction: bus.f_prediction};

`ifdef FE_EXEC_BYPASS_EN
  assign byp = empty && !redirect_q && bus.f_valid;
`else
  assign byp = 1'b0;
`endif

  // Fetch's bundle during a redirect cycle is wrong-path, so refuse it.
  assign bus.f_ready = !full && !redirect_q;
  assign e_valid     = !empty || byp;
  assign e_bundle    = byp ? f_bundle : fifo_head;
  assign deq         = e_valid && bus.e_ready;
  assign pop         = deq && !empty;
  // A bypassed bundle consumed this cycle never lands in storage.
  assign push        = bus.f_valid && bus.f_ready && !(byp && bus.e_ready);

  assign actual     = next_pc(bus.resolve_taken, bus.resolve_target, e_bundle.pc4);
  assign mispredict = deq && bus.resolve && (actual != e_bundle.prediction);
  assign clear      = mispredict || bus.flush;

  fe_bundle_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (f_bundle),
    .pop       (pop),
    .clear     (clear),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      redirect_q <= 1'b0;
      brj_q      <= '0;
    end else begin
      redirect_q <= mispredict;
      if (mispredict) brj_q <= actual;
    end
  end

  assign bus.e_valid      = e_valid;
  assign bus.e_pc         = e_bundle.pc;
  assign bus.e_instr      = e_bundle.instr;
  assign bus.e_pc4        = e_bundle.pc4;
  assign bus.e_prediction = e_bundle.prediction;
  assign bus.redirect     = redirect_q;
  assign bus.brj_addr     = brj_q;
  assign bus.count        = fifo_count;

endmodule
